// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: skid-register states and
// payload field constants used when packing {PC, instr} stage buses.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b11
  } skid_state_e;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_skid_reg_sat_cnt.sv
// Saturating up-counter with asynchronous clear; holds at all-ones once reached.
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register with valid/ready handshake, two-entry skid
// buffer (registered in_ready), synchronous flush and occupancy output.
// Define PIPE_SKID_PERF_EN to add saturating stall_cnt / bubble_cnt outputs.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  skid_state_e       r_state, w_state_nxt;
  logic [DATA_W-1:0] r_main_d, r_skid_d;
  logic [DATA_W-1:0] w_main_d_nxt, w_skid_d_nxt;
  logic              w_acc, w_pop;

  // All handshake outputs decode straight from the state flops.
  assign out_valid = (r_state != EMPTY);
  assign in_ready  = (r_state != FULL);
  assign out_data  = r_main_d;
  assign occupancy = (r_state == FULL) ? 2'd2 :
                     (r_state == HALF) ? 2'd1 : 2'd0;

  assign w_acc = in_valid & in_ready;
  assign w_pop = out_valid & out_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_main_d_nxt = r_main_d;
    w_skid_d_nxt = r_skid_d;
    if (flush) begin
      w_state_nxt  = EMPTY;
      w_main_d_nxt = BUBBLE_VAL;
      w_skid_d_nxt = BUBBLE_VAL;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            w_state_nxt  = HALF;
            w_main_d_nxt = in_data;
          end
        end
        HALF: begin
          if (w_acc && w_pop) begin
            w_main_d_nxt = in_data;
          end else if (w_acc) begin
            w_state_nxt  = FULL;
            w_skid_d_nxt = in_data;
          end else if (w_pop) begin
            w_state_nxt  = EMPTY;
            w_main_d_nxt = BUBBLE_VAL;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (w_pop) begin
            w_state_nxt  = HALF;
            w_main_d_nxt = r_skid_d;
            w_skid_d_nxt = BUBBLE_VAL;
          end
        end
        default: begin
          w_state_nxt  = EMPTY;
          w_main_d_nxt = BUBBLE_VAL;
          w_skid_d_nxt = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= EMPTY;
      r_main_d <= BUBBLE_VAL;
      r_skid_d <= BUBBLE_VAL;
    end else begin
      r_state  <= w_state_nxt;
      r_main_d <= w_main_d_nxt;
      r_skid_d <= w_skid_d_nxt;
    end
  end

`ifdef PIPE_SKID_PERF_EN
  logic w_stall, w_bubble;

  assign w_stall  = out_valid & ~out_ready;
  assign w_bubble = ~out_valid;

  sat_cnt #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );

  sat_cnt #(.W(32)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_bubble),
    .o_cnt (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus randomized
// traffic compared against a queue-based FIFO reference model.
module tb_pipe_skid_reg;

  localparam int DATA_W = 64;
  localparam logic [DATA_W-1:0] BUBBLE = '0;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_SKID_PERF_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  // Reference model: a FIFO of at most two entries. Pops happen before pushes
  // within an edge; a flush empties it and drops the incoming item.
  logic [DATA_W-1:0] mq[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else begin
      bit can_take;
      can_take = (mq.size() < 2);
      if (mq.size() > 0 && out_ready) mq.pop_front();
      if (flush) mq.delete();
      else if (in_valid && can_take) mq.push_back(in_data);
    end
  end

  // Upstream protocol: a waiting item must stay valid and stable.
  logic              mon_wait = 1'b0;
  logic [DATA_W-1:0] mon_data = '0;

  always @(negedge clk) begin
    if (mon_wait && !reset && !flush)
      assert (in_valid && in_data == mon_data)
        else $error("protocol: waiting input item dropped or changed");
    mon_wait = in_valid && !in_ready && !flush && !reset;
    mon_data = in_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    @(posedge clk); #2;
    reset = 1;
    @(posedge clk); #2;
    reset = 0;
  endtask

  task automatic test_reset();
    flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    reset = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== BUBBLE) begin errors++; $display("FAIL reset_out_data: got %h want %h", out_data, BUBBLE); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    @(posedge clk); #2;
    reset = 0;
  endtask

  task automatic test_streaming();
    apply_reset();
    out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1; in_data = DATA_W'(k);
      @(posedge clk); #1;
      checks++; if (out_data !== DATA_W'(k)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", k, out_data, DATA_W'(k)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", k, in_ready); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d]: got %0d want 1", k, occupancy); end
    end
    in_valid = 0;
    @(posedge clk); #1;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain_occ: got %0d want 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stall_skid();
    apply_reset();
    out_ready = 0; in_valid = 1; in_data = 'hA;
    @(posedge clk); #1;
    checks++; if (out_data !== DATA_W'('hA)) begin errors++; $display("FAIL skid_half_data: got %h want a", out_data); end
    in_data = 'hB;
    @(posedge clk); #1;
    in_valid = 0;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL skid_full_occ: got %0d want 2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_full_in_ready: got %b want 0", in_ready); end
    checks++; if (out_data !== DATA_W'('hA)) begin errors++; $display("FAIL skid_full_data: got %h want a", out_data); end
    @(posedge clk); #1;
    checks++; if (out_data !== DATA_W'('hA)) begin errors++; $display("FAIL skid_hold_data: got %h want a", out_data); end
    out_ready = 1;
    @(posedge clk); #1;
    checks++; if (out_data !== DATA_W'('hB)) begin errors++; $display("FAIL skid_pop1_data: got %h want b", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_pop1_in_ready: got %b want 1", in_ready); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL skid_pop1_occ: got %0d want 1", occupancy); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_pop2_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== BUBBLE) begin errors++; $display("FAIL skid_pop2_data: got %h want %h", out_data, BUBBLE); end
  endtask

  task automatic test_flush_full();
    apply_reset();
    out_ready = 0; in_valid = 1; in_data = 'hA;
    @(posedge clk); #1;
    in_data = 'hB;
    @(posedge clk); #1;
    flush = 1; in_data = 'hC;
    @(posedge clk); #1;
    flush = 0; in_valid = 0; out_ready = 1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== BUBBLE) begin errors++; $display("FAIL flush_data: got %h want %h", out_data, BUBBLE); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after_valid[%0d]: got %b want 0 (data %h)", k, out_valid, out_data); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 0; in_valid = 1; in_data = 'h5A;
    @(posedge clk); #1;
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b want 1", out_valid); end
    #2 reset = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_data !== BUBBLE) begin errors++; $display("FAIL areset_data: got %h want %h", out_data, BUBBLE); end
    #1 reset = 0;
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_after_valid[%0d]: got %b want 0", k, out_valid); end
    end
  endtask

  task automatic test_bubble();
`ifdef PIPE_SKID_PERF_EN
    logic [31:0] b0;
`endif
    apply_reset();
`ifdef PIPE_SKID_PERF_EN
    b0 = bubble_cnt;
`endif
    out_ready = 1; in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid[%0d]: got %b want 0", k, out_valid); end
      checks++; if (out_data !== BUBBLE) begin errors++; $display("FAIL bubble_data[%0d]: got %h want %h", k, out_data, BUBBLE); end
    end
`ifdef PIPE_SKID_PERF_EN
    checks++; if (bubble_cnt !== b0 + 32'd3) begin errors++; $display("FAIL bubble_cnt: got %0d want %0d", bubble_cnt, b0 + 32'd3); end
`endif
  endtask

`ifdef PIPE_SKID_PERF_EN
  task automatic test_perf();
    apply_reset();
    out_ready = 0; in_valid = 1; in_data = 'h7;
    @(posedge clk); #1;
    in_valid = 0;
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_stall_start: got %0d want 0", stall_cnt); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_stall_5: got %0d want 5", stall_cnt); end
    force dut.u_stall_cnt.r_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.u_stall_cnt.r_cnt;
    @(posedge clk); #1;
    checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_stall_sat: got %h want ffffffff", stall_cnt); end
  endtask
`endif

  task automatic test_random();
    bit hold;
    logic [DATA_W-1:0] exp_data;
    apply_reset();
    hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      hold      = in_valid && !in_ready && !flush;
      @(posedge clk); #1;
      exp_data = (mq.size() > 0) ? mq[0] : BUBBLE;
      checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", c, out_valid, (mq.size() > 0)); end
      checks++; if (out_data !== exp_data) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", c, out_data, exp_data); end
      checks++; if (in_ready !== (mq.size() < 2)) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready, (mq.size() < 2)); end
      checks++; if (occupancy !== 2'(mq.size())) begin errors++; $display("FAIL rand_occ[%0d]: got %0d want %0d", c, occupancy, mq.size()); end
    end
    flush = 0; in_valid = 0;
  endtask

  initial begin
    reset = 0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    #2;
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush_full();
    test_async_reset();
    test_bubble();
`ifdef PIPE_SKID_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
